// File: rtl/dbg_mon_mem_access.sv
// Debug monitor memory-access engine: turns JTAG debug strobes into word reads/writes on an Avalon-style master.
// Optional feature macro DBG_MON_MEM_TIMEOUT_EN aborts accesses stalled for TIMEOUT_CYCLES waitrequest cycles.
module dbg_mon_mem_access #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            r_state,  w_state_nxt;
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic              r_read,   w_read_nxt;
  logic              r_write,  w_write_nxt;
  logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
  logic [DATA_W-1:0] r_mon,    w_mon_nxt;
  logic              r_ready,  w_ready_nxt;
  logic              r_error,  w_error_nxt;
  logic              w_any_strobe;

`ifdef DBG_MON_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
`endif

  assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_mon   <= '0;
      r_ready <= 1'b1;
      r_error <= 1'b0;
`ifdef DBG_MON_MEM_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_read  <= w_read_nxt;
      r_write <= w_write_nxt;
      r_wdata <= w_wdata_nxt;
      r_mon   <= w_mon_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
`ifdef DBG_MON_MEM_TIMEOUT_EN
      r_wait_cnt <= w_wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_read_nxt  = r_read;
    w_write_nxt = r_write;
    w_wdata_nxt = r_wdata;
    w_mon_nxt   = r_mon;
    w_ready_nxt = r_ready;
    w_error_nxt = r_error;
`ifdef DBG_MON_MEM_TIMEOUT_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif
    case (r_state)
      IDLE: begin
`ifdef DBG_MON_MEM_TIMEOUT_EN
        w_wait_cnt_nxt = '0;
`endif
        if (take_action_ocimem_b) begin
          w_wdata_nxt = jdo[34:3];
          w_mon_nxt   = jdo[34:3];
          w_write_nxt = 1'b1;
          w_ready_nxt = 1'b0;
          w_error_nxt = 1'b0;
          w_state_nxt = WR;
        end else if (take_action_ocimem_a) begin
          w_addr_nxt  = jdo[17+ADDR_W-1:17];
          w_error_nxt = 1'b0;
          if (jdo[35]) begin
            w_read_nxt  = 1'b1;
            w_ready_nxt = 1'b0;
            w_state_nxt = RD;
          end
        end else if (take_no_action_ocimem_a) begin
          w_read_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
          w_error_nxt = 1'b0;
          w_state_nxt = RD;
        end
      end
      RD, WR: begin
        // Strobes arriving mid-access are dropped; the access itself still finishes.
        if (w_any_strobe) w_error_nxt = 1'b1;
        if (!mem_waitrequest) begin
          if (r_state == RD) w_mon_nxt = mem_readdata;
          w_addr_nxt  = r_addr + 1'b1;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
`ifdef DBG_MON_MEM_TIMEOUT_EN
        end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          w_ready_nxt = 1'b1;
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
`endif
        end
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_ready_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_address   = r_addr;
  assign mem_read      = r_read;
  assign mem_write     = r_write;
  assign mem_writedata = r_wdata;
  assign MonDReg       = r_mon;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_dbg_mon_mem_access.sv
// Table-driven bench for dbg_mon_mem_access with a simple wait-state slave model and hand-written corner cases.
module tb_dbg_mon_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata, MonDReg;
  logic        mem_waitrequest, monitor_ready, monitor_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbg_mon_mem_access #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  typedef struct {
    logic [2:0]  stb;    // {ocimem_b, ocimem_a, no_action_a}
    logic [37:0] j;
    int          waits;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    logic [7:0]  first;
    logic [31:0] mon;
    logic [7:0]  addr;
    logic        busy;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] ja(input logic auto_rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = auto_rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jw(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Pulse a strobe set, then act as a slave inserting 'waits' wait states per access.
  task automatic do_op(input logic [2:0] stb, input logic [37:0] j, input int waits,
                       input logic [31:0] rd, output int nrd, output int nwr,
                       output logic [7:0] first, output logic busy, output logic stable);
    logic [31:0] wd;
    jdo = j;
    {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = stb;
    tick();
    {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = 3'b000;
    first = mem_address;
    busy = ~monitor_ready;
    wd = mem_writedata;
    nrd = 0;
    nwr = 0;
    stable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (!(mem_read || mem_write)) break;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read && mem_write) || mem_address !== first || mem_writedata !== wd) stable = 1'b0;
      mem_waitrequest = (k < waits);
      mem_readdata = (k < waits) ? 32'hBAD0BAD0 : rd;
      tick();
    end
    mem_waitrequest = 1'b0;
  endtask

  initial begin
    int nrd, nwr;
    logic [7:0] first;
    logic busy, stable;
    logic [31:0] mon_keep;

    tv[0] = '{3'b010, ja(1'b1, 8'h10), 0, 32'hDEADBEEF, 1, 0, 8'h10, 32'hDEADBEEF, 8'h11, 1'b1};
    tv[1] = '{3'b100, jw(32'h12345678), 3, 32'h0, 0, 4, 8'h11, 32'h12345678, 8'h12, 1'b1};
    tv[2] = '{3'b010, ja(1'b0, 8'hFF), 0, 32'h0, 0, 0, 8'hFF, 32'h12345678, 8'hFF, 1'b0};
    tv[3] = '{3'b001, 38'h0, 1, 32'hA5A5A5A5, 2, 0, 8'hFF, 32'hA5A5A5A5, 8'h00, 1'b1};
    tv[4] = '{3'b001, 38'h0, 0, 32'h00000001, 1, 0, 8'h00, 32'h00000001, 8'h01, 1'b1};
    tv[5] = '{3'b100, jw(32'hCAFEF00D), 2, 32'h0, 0, 3, 8'h01, 32'hCAFEF00D, 8'h02, 1'b1};
    tv[6] = '{3'b010, ja(1'b1, 8'h80), 2, 32'h5555AAAA, 3, 0, 8'h80, 32'h5555AAAA, 8'h81, 1'b1};
    tv[7] = '{3'b110, jw(32'h0F0F0F0F), 0, 32'h0, 0, 1, 8'h81, 32'h0F0F0F0F, 8'h82, 1'b1};
    tv[8] = '{3'b011, ja(1'b0, 8'h40), 0, 32'h0, 0, 0, 8'h40, 32'h0F0F0F0F, 8'h40, 1'b0};

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    mem_readdata = '0;
    mem_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst_addr", mem_address, 0);
    chk("rst_read", mem_read, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_wdata", mem_writedata, 0);
    chk("rst_mon", MonDReg, 0);
    chk("rst_ready", monitor_ready, 1);
    chk("rst_error", monitor_error, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_op(tv[i].stb, tv[i].j, tv[i].waits, tv[i].rd, nrd, nwr, first, busy, stable);
      chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d_nrd", i), nrd, tv[i].nrd);
      chk($sformatf("v%0d_nwr", i), nwr, tv[i].nwr);
      chk($sformatf("v%0d_first", i), first, tv[i].first);
      chk($sformatf("v%0d_stable", i), stable, 1);
      chk($sformatf("v%0d_mon", i), MonDReg, tv[i].mon);
      chk($sformatf("v%0d_addr", i), mem_address, tv[i].addr);
      chk($sformatf("v%0d_ready", i), monitor_ready, 1);
      chk($sformatf("v%0d_err", i), monitor_error, 0);
      if (tv[i].nwr > 0) chk($sformatf("v%0d_wdata", i), mem_writedata, tv[i].mon);
    end

    // Busy collision: a second read strobe during a 5-wait read at 0x40.
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    nrd = 0;
    for (int k = 0; k < 60; k++) begin
      if (!mem_read) break;
      nrd++;
      mem_waitrequest = (k < 5);
      mem_readdata = (k < 5) ? 32'hBAD0BAD0 : 32'h600DF00D;
      take_no_action_ocimem_a = (k == 2);
      tick();
    end
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest = 1'b0;
    chk("coll_nrd", nrd, 6);
    chk("coll_err", monitor_error, 1);
    chk("coll_mon", MonDReg, 32'h600DF00D);
    chk("coll_addr", mem_address, 8'h41);
    tick();
    chk("coll_noread", mem_read, 0);

    // Same-cycle b and a: write wins and the sticky error clears.
    do_op(3'b110, jw(32'h77777777), 0, 32'h0, nrd, nwr, first, busy, stable);
    chk("prio_nrd", nrd, 0);
    chk("prio_nwr", nwr, 1);
    chk("prio_first", first, 8'h41);
    chk("prio_err", monitor_error, 0);
    chk("prio_mon", MonDReg, 32'h77777777);
    chk("prio_addr", mem_address, 8'h42);

`ifdef DBG_MON_MEM_TIMEOUT_EN
    mon_keep = MonDReg;
    jdo = ja(1'b1, 8'h20);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    mem_waitrequest = 1'b1;
    nrd = 0;
    for (int k = 0; k < 20; k++) begin
      if (!mem_read) break;
      nrd++;
      tick();
    end
    mem_waitrequest = 1'b0;
    chk("to_nrd", nrd, 4);
    chk("to_err", monitor_error, 1);
    chk("to_addr", mem_address, 8'h20);
    chk("to_mon", MonDReg, mon_keep);
    chk("to_ready", monitor_ready, 1);
`else
    mon_keep = MonDReg;
`endif

    // Reset while the slave is still stalling a read.
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest = 1'b1;
    chk("rmid_read_on", mem_read, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_read", mem_read, 0);
    chk("rmid_write", mem_write, 0);
    chk("rmid_mon", MonDReg, 0);
    chk("rmid_addr", mem_address, 0);
    chk("rmid_ready", monitor_ready, 1);
    chk("rmid_err", monitor_error, 0);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
